// File: rtl/ddr_read_dma_mc.sv
// ddr_read_dma_mc: multi-channel AXI4 read DMA owning the single DDR read port.
// Each channel is programmed with a base address, burst count and per-burst
// stride. One burst is outstanding at a time. Channels are served round-robin
// among those whose buffer can take a whole burst. Returned beats are steered
// to the granted channel.
//
// Ports:
//   system_clk, rst_n        clock, asynchronous active-low reset
//   ch_start                 per-channel start pulse (latches that channel's config)
//   ch_base_addr/ch_burst_num/ch_stride  packed per-channel config, channel i at slice i
//   ch_ready                 channel buffer can accept a full burst (sampled in IDLE)
//   ch_busy, ch_done         channel has work remaining / last burst completed pulse
//   rd_data, rd_valid, rd_last  beat stream to clients (rd_valid one-hot)
//   rd_err, rd_err_ch, rd_err_clear  sticky read-error flag and first failing channel
//   m00_axi_*                AXI4 read address / read data channels
module ddr_read_dma_mc #(
   parameter int unsigned MEM_ADDR_WIDTH = 32,
   parameter int unsigned MEM_DATA_WIDTH = 512,
   parameter int unsigned NUM_CH         = 4,
   parameter int unsigned BURST_LEN      = 64,
   parameter int unsigned LEN_WIDTH      = 16
) (
   input  logic                               system_clk,
   input  logic                               rst_n,
   input  logic [NUM_CH-1:0]                  ch_start,
   input  logic [NUM_CH*MEM_ADDR_WIDTH-1:0]   ch_base_addr,
   input  logic [NUM_CH*LEN_WIDTH-1:0]        ch_burst_num,
   input  logic [NUM_CH*MEM_ADDR_WIDTH-1:0]   ch_stride,
   input  logic [NUM_CH-1:0]                  ch_ready,
   output logic [NUM_CH-1:0]                  ch_busy,
   output logic [NUM_CH-1:0]                  ch_done,
   output logic [MEM_DATA_WIDTH-1:0]          rd_data,
   output logic [NUM_CH-1:0]                  rd_valid,
   output logic                               rd_last,
   output logic                               rd_err,
   output logic [2:0]                         rd_err_ch,
   input  logic                               rd_err_clear,
   output logic [MEM_ADDR_WIDTH-1:0]          m00_axi_araddr,
   output logic [7:0]                         m00_axi_arlen,
   output logic [2:0]                         m00_axi_arsize,
   output logic [1:0]                         m00_axi_arburst,
   output logic                               m00_axi_arlock,
   output logic [3:0]                         m00_axi_arcache,
   output logic [2:0]                         m00_axi_arprot,
   output logic [3:0]                         m00_axi_arqos,
   output logic                               m00_axi_arvalid,
   input  logic                               m00_axi_arready,
   input  logic [MEM_DATA_WIDTH-1:0]          m00_axi_rdata,
   input  logic [1:0]                         m00_axi_rresp,
   input  logic                               m00_axi_rlast,
   input  logic                               m00_axi_rvalid,
   output logic                               m00_axi_rready
);

   localparam int unsigned GW = $clog2(NUM_CH);

   typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

   state_t                    state;
   logic [GW-1:0]             gnt;
   logic [GW-1:0]             rr_ptr;

   logic [MEM_ADDR_WIDTH-1:0] addr       [NUM_CH];
   logic [MEM_ADDR_WIDTH-1:0] stride     [NUM_CH];
   logic [LEN_WIDTH-1:0]      cnt        [NUM_CH];
   logic [LEN_WIDTH-1:0]      num        [NUM_CH];
   logic [MEM_ADDR_WIDTH-1:0] pend_base  [NUM_CH];
   logic [MEM_ADDR_WIDTH-1:0] pend_stride[NUM_CH];
   logic [LEN_WIDTH-1:0]      pend_num   [NUM_CH];
   logic [NUM_CH-1:0]         active;
   logic [NUM_CH-1:0]         pending;

   logic [NUM_CH-1:0]         eligible;
   logic [NUM_CH-1:0]         gnt_oh;
   logic                      pick_vld;
   logic [GW-1:0]             pick;
   logic                      beat_hs;
   logic                      burst_end;

   // Constant AR fields
   assign m00_axi_arsize  = 3'($clog2(MEM_DATA_WIDTH/8));
   assign m00_axi_arburst = 2'b01;
   assign m00_axi_arlock  = 1'b0;
   assign m00_axi_arcache = 4'b0011;
   assign m00_axi_arprot  = 3'b000;
   assign m00_axi_arqos   = 4'b0000;

   assign beat_hs   = (state == DATA) && m00_axi_rvalid;
   assign burst_end = beat_hs && m00_axi_rlast;

   assign ch_busy = active | pending;
   assign rd_data = m00_axi_rdata;
   assign rd_last = beat_hs && m00_axi_rlast;

   // A channel restarted in the same cycle is held out of arbitration so the
   // grant never captures an address that is being replaced.
   assign eligible = active & ch_ready & ~ch_start;

   always_comb begin
      gnt_oh   = '0;
      rd_valid = '0;
      if (state != IDLE) gnt_oh[gnt] = 1'b1;
      if (state == DATA) rd_valid[gnt] = m00_axi_rvalid;
   end

   // Round-robin search starting at rr_ptr
   always_comb begin
      int unsigned idx;
      idx      = 0;
      pick_vld = 1'b0;
      pick     = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (!pick_vld && eligible[idx]) begin
            pick_vld = 1'b1;
            pick     = GW'(idx);
         end
      end
   end

   always_ff @(posedge system_clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         gnt             <= '0;
         rr_ptr          <= '0;
         active          <= '0;
         pending         <= '0;
         ch_done         <= '0;
         m00_axi_araddr  <= '0;
         m00_axi_arlen   <= '0;
         m00_axi_arvalid <= 1'b0;
         m00_axi_rready  <= 1'b0;
         rd_err          <= 1'b0;
         rd_err_ch       <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            addr[i]        <= '0;
            stride[i]      <= '0;
            cnt[i]         <= '0;
            num[i]         <= '0;
            pend_base[i]   <= '0;
            pend_stride[i] <= '0;
            pend_num[i]    <= '0;
         end
      end else begin
         ch_done <= '0;

         // Per-channel context
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_start[i]) begin
               if (gnt_oh[i] && !burst_end) begin
                  // Granted burst still in flight: park the new config until it ends.
                  pending[i]     <= 1'b1;
                  pend_base[i]   <= ch_base_addr[i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
                  pend_stride[i] <= ch_stride[i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
                  pend_num[i]    <= ch_burst_num[i*LEN_WIDTH +: LEN_WIDTH];
               end else begin
                  // Includes a start coinciding with the granted burst's last
                  // beat: the new config wins and the old burst is not counted.
                  pending[i] <= 1'b0;
                  addr[i]    <= ch_base_addr[i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
                  stride[i]  <= ch_stride[i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
                  num[i]     <= ch_burst_num[i*LEN_WIDTH +: LEN_WIDTH];
                  cnt[i]     <= '0;
                  active[i]  <= (ch_burst_num[i*LEN_WIDTH +: LEN_WIDTH] != '0);
                  ch_done[i] <= (ch_burst_num[i*LEN_WIDTH +: LEN_WIDTH] == '0);
               end
            end else if (gnt_oh[i] && burst_end) begin
               if (pending[i]) begin
                  pending[i] <= 1'b0;
                  addr[i]    <= pend_base[i];
                  stride[i]  <= pend_stride[i];
                  num[i]     <= pend_num[i];
                  cnt[i]     <= '0;
                  active[i]  <= (pend_num[i] != '0);
                  ch_done[i] <= (pend_num[i] == '0);
               end else begin
                  addr[i] <= addr[i] + stride[i];
                  cnt[i]  <= cnt[i] + LEN_WIDTH'(1);
                  if (cnt[i] == num[i] - LEN_WIDTH'(1)) begin
                     active[i]  <= 1'b0;
                     ch_done[i] <= 1'b1;
                  end
               end
            end
         end

         // Burst sequencer
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  gnt             <= pick;
                  m00_axi_araddr  <= addr[pick];
                  m00_axi_arlen   <= 8'(BURST_LEN - 1);
                  m00_axi_arvalid <= 1'b1;
                  state           <= REQ;
               end
            end
            REQ: begin
               if (m00_axi_arready) begin
                  m00_axi_arvalid <= 1'b0;
                  m00_axi_rready  <= 1'b1;
                  rr_ptr          <= (gnt == GW'(NUM_CH - 1)) ? '0 : gnt + GW'(1);
                  state           <= DATA;
               end
            end
            DATA: begin
               if (burst_end) begin
                  m00_axi_rready <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // Sticky error; a new error outranks a simultaneous clear.
         if (beat_hs && (m00_axi_rresp != 2'b00)) begin
            rd_err <= 1'b1;
            if (!rd_err || rd_err_clear) rd_err_ch <= 3'(gnt);
         end else if (rd_err_clear) begin
            rd_err    <= 1'b0;
            rd_err_ch <= '0;
         end
      end
   end

endmodule

// File: doc/ddr_read_dma_mc.md
Name: ddr_read_dma_mc

Overview:
Multi-channel AXI4 read DMA that owns the single read port to DDR and serves NUM_CH independent streaming clients, such as the weight/bias loader and one or more feature buffers. Each channel is programmed with a base address, a burst count and a per-burst stride. Bursts are issued one at a time, with round-robin arbitration among channels whose buffers can accept a full burst. Returned beats are steered to the granted channel.

Parameters:
MEM_ADDR_WIDTH, 32, AXI/channel address width
MEM_DATA_WIDTH, 512, AXI data width; arsize = log2(MEM_DATA_WIDTH/8)
NUM_CH, 4, number of client channels (2..8)
BURST_LEN, 64, beats per burst (1..256); arlen = BURST_LEN-1
LEN_WIDTH, 16, width of per-channel burst count

Ports:
system_clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ch_start  in  NUM_CH  per-channel 1-cycle pulse; latches that channel's config
ch_base_addr  in  NUM_CH*MEM_ADDR_WIDTH  start address, channel i at slice i
ch_burst_num  in  NUM_CH*LEN_WIDTH  bursts to fetch
ch_stride  in  NUM_CH*MEM_ADDR_WIDTH  address increment per burst
ch_ready  in  NUM_CH  channel buffer can accept a full burst
ch_busy  out  NUM_CH  channel has bursts remaining
ch_done  out  NUM_CH  1-cycle pulse when the channel's last burst completes
rd_data  out  MEM_DATA_WIDTH  returned beat, combinational from m00_axi_rdata
rd_valid  out  NUM_CH  one-hot beat strobe to the granted channel
rd_last  out  1  last beat of burst
rd_err  out  1  sticky: some beat returned rresp != 0
rd_err_ch  out  3  channel of the first error
rd_err_clear  in  1  clears rd_err and rd_err_ch
m00_axi_araddr/arlen/arsize/arburst/arlock/arcache/arprot/arqos/arvalid  out  AXI4 AR channel
m00_axi_arready  in  1
m00_axi_rdata  in  MEM_DATA_WIDTH
m00_axi_rresp  in  2
m00_axi_rlast, m00_axi_rvalid  in  1
m00_axi_rready  out  1

Behaviour:
- Reset: state IDLE; all per-channel active/pending flags, counters and addresses 0; araddr 0; arlen 0; arvalid 0; rready 0; ch_busy 0; ch_done 0; rd_err 0; rd_err_ch 0; round-robin pointer 0 (channel 0 has highest priority first). Reset mid-burst abandons the burst; no done pulse is issued.
- Constant AR fields: arburst INCR (2'b01), arlock 0, arcache 4'b0011, arprot 0, arqos 0.
- ch_start on an idle channel:
  - Next cycle: addr = base, cnt = 0, active = (burst_num != 0).
  - If burst_num == 0: ch_done pulses next cycle and no AR is issued.
- ch_start on the channel currently granted (REQ/DATA):
  - The new config is stored as pending and replaces the context when the burst ends.
  - The old burst does not advance the counter and produces no ch_done.
- ch_start on a non-granted active channel reloads it immediately.
- ch_busy[i] = active[i] | pending[i].
- FSM IDLE -> REQ -> DATA -> IDLE:
  - IDLE: eligible = active & ch_ready. Grant the first eligible channel at or after rr_ptr (wrap modulo NUM_CH). On grant, register araddr = addr[g] and arlen = BURST_LEN-1; move to REQ. If nothing is eligible, stay in IDLE.
  - REQ: arvalid = 1; araddr/arlen held stable until arready; then go to DATA. rr_ptr = g+1 mod NUM_CH, updated on entry to DATA.
  - DATA: rready = 1. rd_valid[g] = rvalid. rd_last = rvalid & rlast.
  - On rvalid & rlast: addr[g] += stride[g] (wraps modulo 2^MEM_ADDR_WIDTH) and cnt[g]++. If cnt[g] == burst_num-1, active[g] = 0 and ch_done[g] pulses the next cycle. Return to IDLE.
- Minimum gap from rlast to the next arvalid is 2 cycles (IDLE, REQ).
- ch_ready is sampled only in IDLE. Deasserting it mid-burst does not stall the bus; the client guarantees space for the full burst.
- Errors: a beat with rvalid & rready & rresp != 0 sets rd_err. rd_err_ch captures g only if rd_err was 0. If rd_err_clear coincides with a new error, the new error wins. Data is still forwarded.
- Only one burst is outstanding at any time. No 4KB-boundary check is performed; the programmer keeps stride and base aligned.

Test Plan:
- NUM_CH=4, BURST_LEN=64: start ch0 with base 0x1000_0000, burst_num 3, stride 0x1000, ch_ready=1 -> ARs at 0x1000_0000/0x1000_1000/0x1000_2000, arlen 63, 192 rd_valid[0] beats, ch_done[0] once, ch_busy[0] falls with done.
- ch0..ch3 all started with burst_num 2 and ready -> AR grant order 0,1,2,3,0,1,2,3; each ch_done pulses after its 2nd burst.
- ch1 ch_ready=0 while ch2 ready -> ch2 is served; raising ch1 ready -> ch1 is granted at the next IDLE after the current burst.
- arready held low for 10 cycles -> arvalid stays high and araddr/arlen stable; burst proceeds once arready=1.
- Slave returns rresp=2'b10 on beat 5 of a ch3 burst -> rd_err=1, rd_err_ch=3, remaining beats still delivered; rd_err_clear -> 0.
- ch_start with burst_num 0 -> ch_done next cycle, no AR; ch_start to granted ch1 mid-burst with new base 0x2000_0000 -> next ch1 AR at 0x2000_0000, cnt restarts, no done for the old context.
